// File: rtl/lcd_bus_arbiter_if.sv
// Bundle of requester-side handshake and LCD pin signals for lcd_bus_arbiter.
// master = requesters / LCD pins observer, slave = the arbiter itself.
interface lcd_bus_arbiter_if;
  logic [1:0] req;
  logic       rs0;
  logic       rs1;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic [1:0] ack;
  logic       busy;
  logic [1:0] lcd_flags;
  logic [3:0] lcd_data;

  modport master (
    output req, rs0, rs1, byte0, byte1,
    input  ack, busy, lcd_flags, lcd_data
  );

  modport slave (
    input  req, rs0, rs1, byte0, byte1,
    output ack, busy, lcd_flags, lcd_data
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing a 4-bit HD44780 bus between two byte requesters;
// sends each byte as two nibbles with setup/pulse/gap timing, then a busy wait.
module lcd_bus_arbiter #(
  parameter int T_SETUP = 16,
  parameter int T_PULSE = 16,
  parameter int T_GAP   = 64,
  parameter int T_WAIT  = 4095,
  parameter int T_LONG  = 98304,
  parameter int CW      = 17
) (
  input  logic         qzt_clk,
  input  logic         rst_n,
  input  logic         en,
  lcd_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP_SET = 3'd1,
    UP_PUL = 3'd2,
    GAP    = 3'd3,
    LO_SET = 3'd4,
    LO_PUL = 3'd5,
    WAIT   = 3'd6
  } state_t;

  // Terminal counts: a state lasting N cycles leaves when the counter reads N-1.
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LIM_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LIM_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LIM_GAP   = CW'(T_GAP - 1);
  localparam logic [CW-1:0] LIM_WAIT  = CW'(T_WAIT - 1);
  localparam logic [CW-1:0] LIM_LONG  = CW'(T_LONG - 1);

  // Clear-display and return-home (command bytes 0x00..0x03) need the long wait.
  function automatic logic is_long(input logic rs, input logic [7:0] b);
    return (rs == 1'b0) && (b <= 8'h03);
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          last_r, last_s;
  logic          rs_r, rs_s;
  logic [7:0]    byte_r, byte_s;
  logic          long_r, long_s;
  logic [1:0]    ack_r, ack_s;
  logic          busy_r, busy_s;
  logic [1:0]    flags_r, flags_s;
  logic [3:0]    data_r, data_s;
  logic          win_s;
  logic          win_rs_s;
  logic [7:0]    win_byte_s;

  // Winner selection: lone requester wins, contention goes to the port not served last.
  always_comb begin
    if (bus.req == 2'b11) begin
      win_s = ~last_r;
    end else if (bus.req[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      win_rs_s   = bus.rs1;
      win_byte_s = bus.byte1;
    end else begin
      win_rs_s   = bus.rs0;
      win_byte_s = bus.byte0;
    end
  end

  // Next-state and next-output logic of the transfer sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_ONE;
    last_s  = last_r;
    rs_s    = rs_r;
    byte_s  = byte_r;
    long_s  = long_r;
    ack_s   = 2'b00;
    busy_s  = busy_r;
    flags_s = flags_r;
    data_s  = data_r;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (en && (bus.req != 2'b00)) begin
          last_s  = win_s;
          rs_s    = win_rs_s;
          byte_s  = win_byte_s;
          long_s  = is_long(win_rs_s, win_byte_s);
          ack_s   = {win_s, ~win_s};
          busy_s  = 1'b1;
          data_s  = win_byte_s[7:4];
          flags_s = {win_rs_s, 1'b0};
          state_s = UP_SET;
        end else begin
          state_s = IDLE;
        end
      end
      UP_SET: begin
        if (cnt_r == LIM_SETUP) begin
          flags_s = {rs_r, 1'b1};
          cnt_s   = '0;
          state_s = UP_PUL;
        end else begin
          state_s = UP_SET;
        end
      end
      UP_PUL: begin
        if (cnt_r == LIM_PULSE) begin
          flags_s = {rs_r, 1'b0};
          cnt_s   = '0;
          state_s = GAP;
        end else begin
          state_s = UP_PUL;
        end
      end
      GAP: begin
        if (cnt_r == LIM_GAP) begin
          data_s  = byte_r[3:0];
          cnt_s   = '0;
          state_s = LO_SET;
        end else begin
          state_s = GAP;
        end
      end
      LO_SET: begin
        if (cnt_r == LIM_SETUP) begin
          flags_s = {rs_r, 1'b1};
          cnt_s   = '0;
          state_s = LO_PUL;
        end else begin
          state_s = LO_SET;
        end
      end
      LO_PUL: begin
        if (cnt_r == LIM_PULSE) begin
          flags_s = 2'b00;
          data_s  = 4'h0;
          cnt_s   = '0;
          state_s = WAIT;
        end else begin
          state_s = LO_PUL;
        end
      end
      WAIT: begin
        if (cnt_r == (long_r ? LIM_LONG : LIM_WAIT)) begin
          busy_s  = 1'b0;
          cnt_s   = '0;
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        busy_s  = 1'b0;
        flags_s = 2'b00;
        data_s  = 4'h0;
      end
    endcase
  end

  // State, payload and output registers; reset drops E immediately.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      last_r  <= 1'b1;
      rs_r    <= 1'b0;
      byte_r  <= 8'h00;
      long_r  <= 1'b0;
      ack_r   <= 2'b00;
      busy_r  <= 1'b0;
      flags_r <= 2'b00;
      data_r  <= 4'h0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
      rs_r    <= rs_s;
      byte_r  <= byte_s;
      long_r  <= long_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
      flags_r <= flags_s;
      data_r  <= data_s;
    end
  end

  assign bus.ack       = ack_r;
  assign bus.busy      = busy_r;
  assign bus.lcd_flags = flags_r;
  assign bus.lcd_data  = data_r;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: table of byte transfers checked against a
// cycle-by-cycle expected waveform, plus reset and enable-gating sequences.
module tb_lcd_bus_arbiter;
  localparam int TS = 3;
  localparam int TP = 4;
  localparam int TG = 5;
  localparam int TW = 20;
  localparam int TL = 60;

  typedef struct {
    logic [1:0] req;
    logic       rs0;
    logic [7:0] byte0;
    logic       rs1;
    logic [7:0] byte1;
    logic [1:0] req_post;
    logic [1:0] exp_ack;
    logic       exp_rs;
    logic [3:0] exp_hi;
    logic [3:0] exp_lo;
    int         exp_wait;
  } vec_t;

  logic qzt_clk = 1'b0;
  logic rst_n;
  logic en;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs [11];

  lcd_bus_arbiter_if bus ();

  lcd_bus_arbiter #(
    .T_SETUP(TS), .T_PULSE(TP), .T_GAP(TG), .T_WAIT(TW), .T_LONG(TL), .CW(8)
  ) dut (
    .qzt_clk(qzt_clk),
    .rst_n  (rst_n),
    .en     (en),
    .bus    (bus)
  );

  always #5 qzt_clk = ~qzt_clk;

  function automatic logic [15:0] obs();
    return {7'd0, bus.ack, bus.busy, bus.lcd_flags, bus.lcd_data};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector, wait for its ack, then compare every cycle until busy falls.
  task automatic run_vec(input int idx, input vec_t v, input int en_drop_k, output int waited);
    int b1, b2, b3, b4, b5, len, e0;
    logic [1:0] ea, ef;
    logic       eb;
    logic [3:0] ed;
    b1 = TS; b2 = b1 + TP; b3 = b2 + TG; b4 = b3 + TS; b5 = b4 + TP;
    len = b5 + v.exp_wait;
    bus.req = v.req; bus.rs0 = v.rs0; bus.byte0 = v.byte0;
    bus.rs1 = v.rs1; bus.byte1 = v.byte1;
    waited = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge qzt_clk);
      waited++;
      if (bus.ack != 2'b00) break;
    end
    if (bus.ack == 2'b00) begin
      chk($sformatf("vec%0d_ack_timeout", idx), {14'd0, bus.ack}, {14'd0, v.exp_ack});
      bus.req = 2'b00;
      return;
    end
    for (int k = 0; k <= len; k++) begin
      if (k > 0) @(negedge qzt_clk);
      ea = (k == 0) ? v.exp_ack : 2'b00;
      eb = (k < len);
      if (k < b1)      begin ef = {v.exp_rs, 1'b0}; ed = v.exp_hi; end
      else if (k < b2) begin ef = {v.exp_rs, 1'b1}; ed = v.exp_hi; end
      else if (k < b3) begin ef = {v.exp_rs, 1'b0}; ed = v.exp_hi; end
      else if (k < b4) begin ef = {v.exp_rs, 1'b0}; ed = v.exp_lo; end
      else if (k < b5) begin ef = {v.exp_rs, 1'b1}; ed = v.exp_lo; end
      else             begin ef = 2'b00;            ed = 4'h0;     end
      e0 = errors;
      chk($sformatf("vec%0d_k%0d", idx, k), obs(), {7'd0, ea, eb, ef, ed});
      if (errors != e0) break;
      if (k == 0) begin
        // Scramble the served port's payload: the latched copy must not change.
        bus.req = v.req_post;
        if (v.exp_ack == 2'b01) begin bus.rs0 = ~v.rs0; bus.byte0 = ~v.byte0; end
        else begin bus.rs1 = ~v.rs1; bus.byte1 = ~v.byte1; end
      end
      if (k == en_drop_k) en = 1'b0;
    end
  endtask

  initial begin
    int   w;
    int   seen;
    vec_t g;
    // req, rs0, byte0, rs1, byte1, req_post, exp_ack, exp_rs, hi, lo, wait
    vecs[0]  = '{2'b11, 1'b0, 8'h28, 1'b1, 8'h41, 2'b11, 2'b01, 1'b0, 4'h2, 4'h8, TW};
    vecs[1]  = '{2'b11, 1'b0, 8'h28, 1'b1, 8'h41, 2'b11, 2'b10, 1'b1, 4'h4, 4'h1, TW};
    vecs[2]  = '{2'b11, 1'b1, 8'hA5, 1'b0, 8'h01, 2'b11, 2'b01, 1'b1, 4'hA, 4'h5, TW};
    vecs[3]  = '{2'b11, 1'b1, 8'hA5, 1'b0, 8'h01, 2'b00, 2'b10, 1'b0, 4'h0, 4'h1, TL};
    vecs[4]  = '{2'b01, 1'b0, 8'h28, 1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 4'h2, 4'h8, TW};
    vecs[5]  = '{2'b10, 1'b0, 8'h00, 1'b1, 8'h41, 2'b00, 2'b10, 1'b1, 4'h4, 4'h1, TW};
    vecs[6]  = '{2'b01, 1'b0, 8'h01, 1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 4'h0, 4'h1, TL};
    vecs[7]  = '{2'b01, 1'b0, 8'h04, 1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 4'h0, 4'h4, TW};
    vecs[8]  = '{2'b01, 1'b0, 8'h03, 1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 4'h0, 4'h3, TL};
    vecs[9]  = '{2'b01, 1'b1, 8'h02, 1'b0, 8'h00, 2'b00, 2'b01, 1'b1, 4'h0, 4'h2, TW};
    vecs[10] = '{2'b11, 1'b0, 8'h7E, 1'b0, 8'h00, 2'b00, 2'b10, 1'b0, 4'h0, 4'h0, TL};

    rst_n = 1'b0; en = 1'b0;
    bus.req = 2'b00; bus.rs0 = 1'b0; bus.rs1 = 1'b0; bus.byte0 = 8'h00; bus.byte1 = 8'h00;
    #1;
    chk("reset_state", obs(), 16'h0000);
    repeat (3) @(negedge qzt_clk);
    rst_n = 1'b1;
    en = 1'b1;

    // Abort a port-0 transfer mid upper pulse with an asynchronous reset.
    @(negedge qzt_clk);
    bus.req = 2'b01; bus.rs0 = 1'b0; bus.byte0 = 8'h28;
    for (int i = 0; i < 8; i++) begin
      @(negedge qzt_clk);
      if (bus.ack != 2'b00) break;
    end
    chk("rst_seq_ack", {14'd0, bus.ack}, 16'h0001);
    bus.req = 2'b00;
    repeat (TS + 1) @(negedge qzt_clk);
    chk("rst_seq_E_high", {14'd0, bus.lcd_flags}, 16'h0001);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs(), 16'h0000);
    @(negedge qzt_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge qzt_clk);
      chk($sformatf("post_reset_idle%0d", i), obs(), 16'h0000);
    end

    // Table: contention from reset (0,1,0,1), then singles and wait-length boundaries.
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i], -1, w);

    // Gating: no grant while en=0, grant on the first edge after en rises.
    en = 1'b0;
    bus.req = 2'b01; bus.rs0 = 1'b0; bus.byte0 = 8'h28;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge qzt_clk);
      if (bus.ack != 2'b00 || bus.busy) seen++;
    end
    chk("gate_no_grant", seen[15:0], 16'h0000);
    en = 1'b1;
    g = '{2'b01, 1'b0, 8'h28, 1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 4'h2, 4'h8, TW};
    run_vec(11, g, 6, w);
    chk("gate_ack_latency", w[15:0], 16'h0001);

    // After en fell mid-byte: held request stays ungranted; a dropped one is never granted.
    bus.req = 2'b01;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge qzt_clk);
      if (bus.ack != 2'b00 || bus.busy) seen++;
    end
    chk("en_low_hold", seen[15:0], 16'h0000);
    bus.req = 2'b00;
    @(negedge qzt_clk);
    en = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge qzt_clk);
      if (bus.ack != 2'b00 || bus.busy) seen++;
    end
    chk("dropped_req_no_grant", seen[15:0], 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
